// File: rtl/pill_fill_ctrl.sv
// Pill bottle filling controller: counts synchronized pill events into bottles,
// drives the hopper valve and conveyor, and detects jams and spills.
module pill_fill_ctrl #(
  parameter int TIMEOUT_CYC = 200_000_000,
  parameter int ADV_CYC     = 50_000_000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic       pill_in,
  input  logic [7:0] per_bottle,
  input  logic [7:0] num_bottles,
  output logic       valve_open,
  output logic       bottle_adv,
  output logic [7:0] pill_cnt,
  output logic [7:0] bottle_cnt,
  output logic [7:0] spill_cnt,
  output logic [2:0] state,
  output logic       busy,
  output logic       done,
  output logic       alarm
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(ADV_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW-1:0] A_LAST = AW'(ADV_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_PAUSED  = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4,
    S_JAM     = 3'd5
  } state_t;

  state_t        st;
  logic          sync1, sync2, sync3;
  logic          pill_ev;
  logic [7:0]    per_tgt, num_tgt;
  logic [TW-1:0] timer;
  logic [AW-1:0] adv_cnt;
  logic [7:0]    pill_nxt, pill_now, bottle_nxt;
  logic          target_hit;

  // sync3 only holds the previous synchronized level for edge detection.
  assign pill_ev    = sync2 & ~sync3;
  assign pill_nxt   = (pill_cnt == 8'hFF) ? pill_cnt : pill_cnt + 8'd1;
  // Target test uses the count including a pill arriving this cycle.
  assign pill_now   = pill_ev ? pill_nxt : pill_cnt;
  assign target_hit = (pill_now >= per_tgt);
  assign bottle_nxt = bottle_cnt + 8'd1;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      per_tgt    <= 8'd0;
      num_tgt    <= 8'd0;
      pill_cnt   <= 8'd0;
      bottle_cnt <= 8'd0;
      spill_cnt  <= 8'd0;
      timer      <= '0;
      adv_cnt    <= '0;
    end else begin
      sync1 <= pill_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (st != S_FILL) timer <= '0;
      if (st != S_ADVANCE) adv_cnt <= '0;

      if (abort) begin
        st <= S_IDLE;
      end else begin
        case (st)
          S_IDLE, S_DONE: begin
            if (start && per_bottle != 8'd0 && num_bottles != 8'd0) begin
              per_tgt    <= per_bottle;
              num_tgt    <= num_bottles;
              pill_cnt   <= 8'd0;
              bottle_cnt <= 8'd0;
              spill_cnt  <= 8'd0;
              st         <= S_FILL;
            end
          end
          S_FILL: begin
            if (pill_ev) pill_cnt <= pill_nxt;
            timer <= pill_ev ? '0 : timer + 1'b1;
            if (timer == T_LAST)  st <= S_JAM;
            else if (target_hit)  st <= S_ADVANCE;
            else if (pause)       st <= S_PAUSED;
          end
          S_PAUSED: begin
            if (pill_ev) pill_cnt <= pill_nxt;
            if (!pause) st <= target_hit ? S_ADVANCE : S_FILL;
          end
          S_ADVANCE: begin
            if (pill_ev && spill_cnt != 8'hFF) spill_cnt <= spill_cnt + 8'd1;
            if (adv_cnt == A_LAST) begin
              bottle_cnt <= bottle_nxt;
              adv_cnt    <= '0;
              if (bottle_nxt == num_tgt) begin
                st <= S_DONE;
              end else begin
                st       <= S_FILL;
                pill_cnt <= 8'd0;
              end
            end else begin
              adv_cnt <= adv_cnt + 1'b1;
            end
          end
          S_JAM:   st <= S_JAM;
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  // Decoded from the async-reset state register, so reset drops them at once.
  assign state      = st;
  assign valve_open = (st == S_FILL);
  assign bottle_adv = (st == S_ADVANCE);
  assign busy       = (st == S_FILL) || (st == S_PAUSED) || (st == S_ADVANCE);
  assign done       = (st == S_DONE);
  assign alarm      = (st == S_JAM);

endmodule

// File: tb/tb_pill_fill_ctrl.sv
// Bench for pill_fill_ctrl: dut a (short advance, short timeout) covers run, pause,
// jam, start gating and reset; dut b (long advance) covers spill saturation.
module tb_pill_fill_ctrl;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst, start, abort, pause, pill_in;
  logic [7:0] per_bottle, num_bottles;
  logic       a_valve_open, a_bottle_adv, a_busy, a_done, a_alarm;
  logic [7:0] a_pill_cnt, a_bottle_cnt, a_spill_cnt;
  logic [2:0] a_state;
  logic       b_valve_open, b_bottle_adv, b_busy, b_done, b_alarm;
  logic [7:0] b_pill_cnt, b_bottle_cnt, b_spill_cnt;
  logic [2:0] b_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int exp_adv_q[$];
  int obs_adv_q[$];
  int adv_run = 0;

  pill_fill_ctrl #(.TIMEOUT_CYC(10), .ADV_CYC(4)) dut_a (
    .clk_in(clk_in), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .pill_in(pill_in), .per_bottle(per_bottle), .num_bottles(num_bottles),
    .valve_open(a_valve_open), .bottle_adv(a_bottle_adv), .pill_cnt(a_pill_cnt),
    .bottle_cnt(a_bottle_cnt), .spill_cnt(a_spill_cnt), .state(a_state),
    .busy(a_busy), .done(a_done), .alarm(a_alarm)
  );

  pill_fill_ctrl #(.TIMEOUT_CYC(10), .ADV_CYC(2000)) dut_b (
    .clk_in(clk_in), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .pill_in(pill_in), .per_bottle(per_bottle), .num_bottles(num_bottles),
    .valve_open(b_valve_open), .bottle_adv(b_bottle_adv), .pill_cnt(b_pill_cnt),
    .bottle_cnt(b_bottle_cnt), .spill_cnt(b_spill_cnt), .state(b_state),
    .busy(b_busy), .done(b_done), .alarm(b_alarm)
  );

  // Measures each bottle_adv pulse of dut_a in clock cycles.
  always @(negedge clk_in) begin
    if (rst) adv_run = 0;
    else if (a_bottle_adv) adv_run++;
    else if (adv_run != 0) begin
      obs_adv_q.push_back(adv_run);
      adv_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start(input logic [7:0] pb, input logic [7:0] nb);
    per_bottle = pb; num_bottles = nb; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
  endtask

  // One pill: high 3 cycles (count lands on the 3rd edge), sample, then low lo cycles.
  task automatic send_pill(input int lo, output logic [7:0] pa, output logic [7:0] pb,
                           output logic [7:0] sb);
    pill_in = 1'b1;
    repeat (3) @(negedge clk_in);
    pa = a_pill_cnt; pb = b_pill_cnt; sb = b_spill_cnt;
    pill_in = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; pause = 0; pill_in = 0;
    per_bottle = 0; num_bottles = 0;
    @(negedge clk_in);
    n_cmp++; if ({a_state, a_valve_open, a_bottle_adv, a_busy, a_done, a_alarm} !== 8'd0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0", {a_state, a_valve_open, a_bottle_adv, a_busy, a_done, a_alarm}); end
    n_cmp++; if ({a_pill_cnt, a_bottle_cnt, a_spill_cnt} !== 24'd0) begin
      n_bad++; $display("FAIL reset_counts: got %h expected 0", {a_pill_cnt, a_bottle_cnt, a_spill_cnt}); end
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_run();
    logic [7:0] pa, pb, sb, e;
    obs_adv_q.delete(); exp_adv_q.delete();
    pulse_start(8'd3, 8'd2);
    n_cmp++; if (a_state !== 3'd1 || a_valve_open !== 1'b1) begin
      n_bad++; $display("FAIL run_enter_fill: got state %0d valve %b expected 1/1", a_state, a_valve_open); end
    for (int bt = 0; bt < 2; bt++) begin
      for (int p = 1; p <= 3; p++) begin
        exp_q.push_back(8'(p));
        if (p == 3) exp_adv_q.push_back(4);
        send_pill(3, pa, pb, sb);
        e = exp_q.pop_front();
        n_cmp++; if (pa !== e) begin
          n_bad++; $display("FAIL run_pill_cnt: got %0d expected %0d", pa, e); end
      end
      if (bt == 0) begin
        for (int i = 0; i < 20 && a_state != 3'd1; i++) @(negedge clk_in);
        n_cmp++; if (a_state !== 3'd1 || a_pill_cnt !== 8'd0 || a_bottle_cnt !== 8'd1) begin
          n_bad++; $display("FAIL run_after_adv1: got state %0d pill %0d bottle %0d expected 1/0/1", a_state, a_pill_cnt, a_bottle_cnt); end
      end
    end
    for (int i = 0; i < 20 && a_state != 3'd4; i++) @(negedge clk_in);
    n_cmp++; if (a_state !== 3'd4 || a_done !== 1'b1 || a_bottle_cnt !== 8'd2 || a_busy !== 1'b0) begin
      n_bad++; $display("FAIL run_done: got state %0d done %b bottle %0d busy %b expected 4/1/2/0", a_state, a_done, a_bottle_cnt, a_busy); end
    @(negedge clk_in); #1;
    n_cmp++; if (obs_adv_q.size() !== 2) begin
      n_bad++; $display("FAIL run_adv_pulses: got %0d expected 2", obs_adv_q.size()); end
    while (obs_adv_q.size() > 0 && exp_adv_q.size() > 0) begin
      int o, x;
      o = obs_adv_q.pop_front(); x = exp_adv_q.pop_front();
      n_cmp++; if (o !== x) begin
        n_bad++; $display("FAIL run_adv_len: got %0d expected %0d", o, x); end
    end
  endtask

  task automatic test_pause();
    logic [7:0] pa, pb, sb, e;
    obs_adv_q.delete(); exp_adv_q.delete();
    pulse_start(8'd3, 8'd1);
    exp_q.push_back(8'd1);
    send_pill(3, pa, pb, sb);
    e = exp_q.pop_front();
    n_cmp++; if (pa !== e) begin n_bad++; $display("FAIL pause_pill1: got %0d expected %0d", pa, e); end
    pause = 1'b1;
    @(negedge clk_in);
    n_cmp++; if (a_state !== 3'd2 || a_valve_open !== 1'b0) begin
      n_bad++; $display("FAIL pause_enter: got state %0d valve %b expected 2/0", a_state, a_valve_open); end
    for (int p = 2; p <= 3; p++) begin
      exp_q.push_back(8'(p));
      send_pill(3, pa, pb, sb);
      e = exp_q.pop_front();
      n_cmp++; if (pa !== e) begin n_bad++; $display("FAIL pause_pill_cnt: got %0d expected %0d", pa, e); end
    end
    n_cmp++; if (a_state !== 3'd2 || a_valve_open !== 1'b0) begin
      n_bad++; $display("FAIL pause_hold: got state %0d valve %b expected 2/0", a_state, a_valve_open); end
    exp_adv_q.push_back(4);
    pause = 1'b0;
    @(negedge clk_in);
    n_cmp++; if (a_state !== 3'd3 || a_bottle_adv !== 1'b1) begin
      n_bad++; $display("FAIL pause_release_adv: got state %0d adv %b expected 3/1", a_state, a_bottle_adv); end
    for (int i = 0; i < 20 && a_state != 3'd4; i++) @(negedge clk_in);
    @(negedge clk_in); #1;
    n_cmp++; if (a_state !== 3'd4 || obs_adv_q.size() !== 1) begin
      n_bad++; $display("FAIL pause_done: got state %0d pulses %0d expected 4/1", a_state, obs_adv_q.size()); end
    if (obs_adv_q.size() > 0) begin
      int o, x;
      o = obs_adv_q.pop_front(); x = exp_adv_q.pop_front();
      n_cmp++; if (o !== x) begin n_bad++; $display("FAIL pause_adv_len: got %0d expected %0d", o, x); end
    end
  endtask

  task automatic test_jam();
    int fill_n;
    pulse_start(8'd3, 8'd1);
    fill_n = 0;
    while (a_state == 3'd1 && fill_n < 50) begin
      fill_n++;
      @(negedge clk_in);
    end
    n_cmp++; if (fill_n !== 10) begin n_bad++; $display("FAIL jam_fill_cycles: got %0d expected 10", fill_n); end
    n_cmp++; if (a_state !== 3'd5 || a_alarm !== 1'b1 || a_valve_open !== 1'b0) begin
      n_bad++; $display("FAIL jam_alarm: got state %0d alarm %b valve %b expected 5/1/0", a_state, a_alarm, a_valve_open); end
    pulse_start(8'd3, 8'd1);
    repeat (3) @(negedge clk_in);
    n_cmp++; if (a_state !== 3'd5) begin n_bad++; $display("FAIL jam_sticky: got %0d expected 5", a_state); end
    pulse_abort();
    n_cmp++; if (a_state !== 3'd0 || a_alarm !== 1'b0 || a_pill_cnt !== 8'd0 || a_bottle_cnt !== 8'd0) begin
      n_bad++; $display("FAIL jam_abort: got state %0d alarm %b pill %0d bottle %0d expected 0/0/0/0", a_state, a_alarm, a_pill_cnt, a_bottle_cnt); end
  endtask

  task automatic test_zero_and_busy();
    logic [7:0] pa, pb, sb, e;
    pulse_start(8'd0, 8'd2);
    n_cmp++; if (a_state !== 3'd0) begin n_bad++; $display("FAIL zero_per_bottle: got %0d expected 0", a_state); end
    pulse_start(8'd2, 8'd0);
    n_cmp++; if (a_state !== 3'd0) begin n_bad++; $display("FAIL zero_num_bottles: got %0d expected 0", a_state); end
    pulse_start(8'd2, 8'd1);
    n_cmp++; if (a_state !== 3'd1) begin n_bad++; $display("FAIL busy_start_ok: got %0d expected 1", a_state); end
    exp_q.push_back(8'd1);
    send_pill(3, pa, pb, sb);
    e = exp_q.pop_front();
    n_cmp++; if (pa !== e) begin n_bad++; $display("FAIL busy_pill1: got %0d expected %0d", pa, e); end
    pulse_start(8'd5, 8'd1);
    n_cmp++; if (a_state !== 3'd1 || a_pill_cnt !== 8'd1) begin
      n_bad++; $display("FAIL busy_start_ignored: got state %0d pill %0d expected 1/1", a_state, a_pill_cnt); end
    exp_q.push_back(8'd2);
    send_pill(0, pa, pb, sb);
    e = exp_q.pop_front();
    n_cmp++; if (pa !== e || a_state !== 3'd3) begin
      n_bad++; $display("FAIL busy_target_kept: got pill %0d state %0d expected %0d/3", pa, a_state, e); end
    for (int i = 0; i < 20 && a_state != 3'd4; i++) @(negedge clk_in);
  endtask

  task automatic test_spill();
    logic [7:0] pa, pb, sb, e;
    rst = 1'b1; @(negedge clk_in); rst = 1'b0; @(negedge clk_in);
    pulse_start(8'd1, 8'd1);
    exp_q.push_back(8'd1);
    send_pill(0, pa, pb, sb);
    e = exp_q.pop_front();
    n_cmp++; if (pb !== e || b_state !== 3'd3) begin
      n_bad++; $display("FAIL spill_per1_adv: got pill %0d state %0d expected %0d/3", pb, b_state, e); end
    @(negedge clk_in);
    for (int k = 1; k <= 300; k++) begin
      exp_q.push_back(8'((k > 255) ? 255 : k));
      send_pill(1, pa, pb, sb);
      e = exp_q.pop_front();
      n_cmp++; if (sb !== e || pb !== 8'd1) begin
        n_bad++; $display("FAIL spill_cnt: pill %0d got spill %0d pill_cnt %0d expected %0d/1", k, sb, pb, e); end
    end
    n_cmp++; if (b_state !== 3'd3) begin n_bad++; $display("FAIL spill_still_adv: got %0d expected 3", b_state); end
    pulse_abort();
    n_cmp++; if (b_state !== 3'd0 || b_bottle_adv !== 1'b0 || b_spill_cnt !== 8'd255 || b_pill_cnt !== 8'd1 || b_bottle_cnt !== 8'd0) begin
      n_bad++; $display("FAIL spill_abort_hold: got state %0d adv %b spill %0d pill %0d bottle %0d expected 0/0/255/1/0",
                        b_state, b_bottle_adv, b_spill_cnt, b_pill_cnt, b_bottle_cnt); end
  endtask

  task automatic test_reset_mid_adv();
    logic [7:0] pa, pb, sb, e;
    pulse_start(8'd1, 8'd1);
    exp_q.push_back(8'd1);
    send_pill(0, pa, pb, sb);
    e = exp_q.pop_front();
    n_cmp++; if (pa !== e || a_bottle_adv !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre_adv: got pill %0d adv %b expected %0d/1", pa, a_bottle_adv, e); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (a_bottle_adv !== 1'b0 || a_valve_open !== 1'b0) begin
      n_bad++; $display("FAIL rst_async_drive: got adv %b valve %b expected 0/0", a_bottle_adv, a_valve_open); end
    n_cmp++; if ({a_state, a_busy, a_done, a_alarm, a_pill_cnt, a_bottle_cnt, a_spill_cnt} !== 30'd0) begin
      n_bad++; $display("FAIL rst_async_state: got %h expected 0", {a_state, a_busy, a_done, a_alarm, a_pill_cnt, a_bottle_cnt, a_spill_cnt}); end
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_jam();
    test_zero_and_busy();
    test_spill();
    test_reset_mid_adv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
